// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch/decode pipeline types and constants
package fetch_stage_pkg;

  localparam int PC_W_DEF    = 64;
  localparam int INSTR_W_DEF = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_e;

  typedef struct packed {
    logic                   valid;
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } ifid_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry {pc,instr} buffer for a word returned while decode stalls
module fetch_hold_buf
  import fetch_stage_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [PC_W-1:0]    load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  // clear wins so a redirect can never leave a stale word behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, single-outstanding imem requests, IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr
);

  fetch_state_e       state, state_d;
  logic [PC_W-1:0]    pc, pc_d, req_pc, req_pc_d;
  ifid_t              ifid, ifid_d;
  logic               hold_load, hold_clear, hold_valid;
  logic [PC_W-1:0]    hold_pc;
  logic [INSTR_W-1:0] hold_instr;
  logic               outstanding;

  assign imem_req_valid = (state == ST_REQ);
  assign imem_req_addr  = pc;
  assign ifid_valid     = ifid.valid;
  assign ifid_pc        = ifid.pc;
  assign ifid_instr     = ifid.instr;

  fetch_hold_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (hold_load),
    .clear      (hold_clear),
    .load_pc    (req_pc),
    .load_instr (imem_rsp_data),
    .valid      (hold_valid),
    .pc         (hold_pc),
    .instr      (hold_instr)
  );

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    req_pc_d    = req_pc;
    ifid_d      = ifid;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    outstanding = 1'b0;

    // decode consumed the current entry; a delivery below overrides the bubble
    if (!stall) ifid_d.valid = 1'b0;

    unique case (state)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        outstanding = imem_req_ready;
        if (imem_req_ready) begin
          req_pc_d = pc;
          pc_d     = pc + PC_W'(4);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        outstanding = !imem_rsp_valid;
        if (imem_rsp_valid) begin
          if (!stall) begin
            ifid_d.valid = 1'b1;
            ifid_d.pc    = req_pc;
            ifid_d.instr = imem_rsp_data;
            state_d      = ST_REQ;
          end else begin
            hold_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          ifid_d.valid = 1'b1;
          ifid_d.pc    = hold_pc;
          ifid_d.instr = hold_instr;
          hold_clear   = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_DROP: begin
        outstanding = !imem_rsp_valid;
        if (imem_rsp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    // a request still in flight must have its response swallowed before refetching
    if (redirect_valid) begin
      ifid_d.valid = 1'b0;
      pc_d         = {redirect_pc[PC_W-1:2], 2'b00};
      hold_load    = 1'b0;
      hold_clear   = 1'b1;
      state_d      = outstanding ? ST_DROP : ST_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      ifid   <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      req_pc <= req_pc_d;
      ifid   <= ifid_d;
    end
  end

  a_rsp_only_when_pending: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (state == ST_WAIT || state == ST_DROP));

  a_hold_full_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_HOLD) |-> hold_valid);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;

  int nvec = 0;
  int nerr = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h13;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // one plain fetch: accept now, answer on the next cycle
  task automatic fetch_one(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_valids: req_valid=%b ifid_valid=%b, want 0/0", imem_req_valid, ifid_valid);
    end
    nvec++;
    if (ifid_pc !== 64'h0 || ifid_instr !== NOP) begin
      nerr++;
      $display("FAIL reset_ifid: pc=%h instr=%h, want 0/%h", ifid_pc, ifid_instr, NOP);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    nvec++;
    if (imem_req_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle: req_valid=%b, want 0", imem_req_valid);
    end
    tick();
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      nerr++;
      $display("FAIL reset_first_req: valid=%b addr=%h, want 1/0", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'(4 * k)) begin
        nerr++;
        $display("FAIL seq_addr%0d: valid=%b addr=%h, want 1/%h", k, imem_req_valid, imem_req_addr, 64'(4 * k));
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      nvec++;
      if (imem_req_valid !== 1'b0) begin
        nerr++;
        $display("FAIL seq_wait%0d: req_valid=%b, want 0", k, imem_req_valid);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0050_0093;
      tick();
      imem_rsp_valid = 1'b0;
      nvec++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 64'(4 * k) || ifid_instr !== 32'h0050_0093) begin
        nerr++;
        $display("FAIL seq_ifid%0d: got %b/%h/%h, want 1/%h/00500093", k, ifid_valid, ifid_pc, ifid_instr, 64'(4 * k));
      end
    end
  endtask

  task automatic test_stall_wait();
    logic [31:0] d0;
    d0 = $urandom;
    do_reset();
    fetch_one(d0);
    imem_req_ready = 1'b1;
    stall          = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A0_0113;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 64'h0 || ifid_instr !== d0) begin
        nerr++;
        $display("FAIL stall_hold%0d: req=%b ifid=%b/%h/%h, want 0 1/0/%h", i, imem_req_valid, ifid_valid, ifid_pc, ifid_instr, d0);
      end
      tick();
    end
    stall = 1'b0;
    tick();
    nvec++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 64'h4 || ifid_instr !== 32'h00A0_0113) begin
      nerr++;
      $display("FAIL stall_release: ifid=%b/%h/%h, want 1/4/00a00113", ifid_valid, ifid_pc, ifid_instr);
    end
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8) begin
      nerr++;
      $display("FAIL stall_next_req: valid=%b addr=%h, want 1/8", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] d1;
    d1 = $urandom;
    do_reset();
    fetch_one($urandom);
    imem_req_ready = 1'b1;
    stall          = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    tick();
    redirect_valid = 1'b0;
    nvec++;
    if (ifid_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      nerr++;
      $display("FAIL redir_drop: ifid_valid=%b req_valid=%b, want 0/0", ifid_valid, imem_req_valid);
    end
    tick();
    nvec++;
    if (imem_req_valid !== 1'b0) begin
      nerr++;
      $display("FAIL redir_drop_wait: req_valid=%b, want 0", imem_req_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0BAD;
    tick();
    imem_rsp_valid = 1'b0;
    nvec++;
    if (ifid_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100) begin
      nerr++;
      $display("FAIL redir_stale: ifid_valid=%b req=%b/%h, want 0 1/100", ifid_valid, imem_req_valid, imem_req_addr);
    end
    fetch_one(d1);
    nvec++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 64'h100 || ifid_instr !== d1) begin
      nerr++;
      $display("FAIL redir_first: ifid=%b/%h/%h, want 1/100/%h", ifid_valid, ifid_pc, ifid_instr, d1);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    fetch_one($urandom);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    tick();
    redirect_valid = 1'b0;
    nvec++;
    if (ifid_valid !== 1'b0) begin
      nerr++;
      $display("FAIL redir_stall_flush: ifid_valid=%b, want 0", ifid_valid);
    end
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h40) begin
      nerr++;
      $display("FAIL redir_latency: valid=%b addr=%h, want 1/40", imem_req_valid, imem_req_addr);
    end
    stall = 1'b0;
  endtask

  task automatic test_ready_low();
    logic [31:0] d;
    d = $urandom;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
        nerr++;
        $display("FAIL ready_low%0d: valid=%b addr=%h, want 1/0", i, imem_req_valid, imem_req_addr);
      end
      tick();
    end
    fetch_one(d);
    nvec++;
    if (imem_req_addr !== 64'h4 || ifid_pc !== 64'h0 || ifid_instr !== d) begin
      nerr++;
      $display("FAIL ready_low_after: addr=%h ifid=%h/%h, want 4 0/%h", imem_req_addr, ifid_pc, ifid_instr, d);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] d;
    d = $urandom;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    nvec++;
    if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      nerr++;
      $display("FAIL wrap_target: addr=%h, want fffffffffffffffc", imem_req_addr);
    end
    fetch_one(d);
    nvec++;
    if (ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ifid_instr !== d || imem_req_addr !== 64'h0) begin
      nerr++;
      $display("FAIL wrap_next: ifid=%h/%h addr=%h, want fffffffffffffffc/%h 0", ifid_pc, ifid_instr, imem_req_addr, d);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    nvec++;
    if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== 64'h0 || ifid_instr !== NOP) begin
      nerr++;
      $display("FAIL async_reset: req=%b ifid=%b/%h/%h, want 0 0/0/%h", imem_req_valid, ifid_valid, ifid_pc, ifid_instr, NOP);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      nerr++;
      $display("FAIL reset_restart: valid=%b addr=%h, want 1/0", imem_req_valid, imem_req_addr);
    end
  endtask

  // decode consumes IF/ID whenever it is valid and not stalled; that stream must be
  // program order from the last redirect target, each word exactly once
  task automatic test_random_stream();
    logic        pend;
    logic [63:0] pend_addr;
    int          cnt;
    logic [63:0] exp_pc;
    int          consumed;
    bit          quiet;
    do_reset();
    pend     = 1'b0;
    pend_addr = '0;
    cnt      = 0;
    exp_pc   = 64'h0;
    consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      quiet = (cyc >= 2700);
      if (imem_req_valid) begin
        nvec++;
        if (pend) begin
          nerr++;
          $display("FAIL rnd_one_outstanding cyc%0d: new req at %h while %h pending", cyc, imem_req_addr, pend_addr);
        end
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memf(pend_addr);
          pend           = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if (imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        cnt       = $urandom_range(0, 3);
      end
      stall          = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
      redirect_valid = quiet ? 1'b0 : ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
      else
        redirect_pc = {$urandom, $urandom};
      if (redirect_valid) begin
        exp_pc = {redirect_pc[63:2], 2'b00};
      end else if (ifid_valid && !stall) begin
        nvec++;
        if (ifid_pc !== exp_pc || ifid_instr !== memf(exp_pc)) begin
          nerr++;
          $display("FAIL rnd_stream cyc%0d: got %h/%h, want %h/%h", cyc, ifid_pc, ifid_instr, exp_pc, memf(exp_pc));
        end
        consumed++;
        exp_pc = exp_pc + 64'd4;
      end
      tick();
    end
    clear_inputs();
    nvec++;
    if (consumed < 100) begin
      nerr++;
      $display("FAIL rnd_progress: consumed %0d instructions, want at least 100", consumed);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall_wait();
    test_redirect_drop();
    test_redirect_stall();
    test_ready_low();
    test_wrap_and_reset();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
